// File: rtl/dff_pipe.sv
// dff_pipe: elastic register pipeline of DEPTH stages carrying a BIT_WIDTH word.
// Each stage holds a word and a valid bit. Words advance on valid/ready
// handshakes and empty stages always accept, so bubbles collapse toward the
// output while the output is stalled.
// A synchronous flush discards everything, and a registered occupancy count
// tracks how many stages are valid.
// Optional build macro DFF_PIPE_STALL_CNT_EN adds stall_cnt_out, a saturating
// 16-bit count of the edges at which the output is valid but not taken.
module dff_pipe #(
   parameter int BIT_WIDTH = 64,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n_in,
   input  logic [BIT_WIDTH-1:0] d_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic [BIT_WIDTH-1:0] q_output,
   output logic                 valid_out,
   input  logic                 ready_in,
   input  logic                 flush_in,
   output logic [CNT_W-1:0]     occupancy_out
`ifdef DFF_PIPE_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cnt_out
`endif
);

   // Stage state gathered into vectors. Bits are driven from the per-stage
   // generate blocks below.
   wire [DEPTH-1:0]     vld_s;
   wire [DEPTH-1:0]     load_s;
   wire [BIT_WIDTH-1:0] data_s [DEPTH];

   logic                in_xfer_s;
   logic                out_xfer_s;
   logic [CNT_W-1:0]    occ_q;
   logic [CNT_W-1:0]    occ_d;

   // A stage may load when it, or any stage downstream of it, is empty.
   // Ready_in also lets the whole chain shift. This is the bubble-collapsing
   // advance chain, written as a reduction so that no bit depends on another
   // bit of the same vector.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic                 vld_q;
      logic                 vld_d;
      logic [BIT_WIDTH-1:0] data_q;
      logic [BIT_WIDTH-1:0] data_d;
      logic                 src_vld_s;
      logic [BIT_WIDTH-1:0] src_data_s;

      assign load_s[g] = ready_in || !(&vld_s[DEPTH-1:g]);

      if (g == 0) begin : g_src_in
         assign src_vld_s  = valid_in;
         assign src_data_s = d_in;
      end else begin : g_src_prev
         assign src_vld_s  = vld_s[g-1];
         assign src_data_s = data_s[g-1];
      end

      // Next-state for this stage: flush clears, load copies the source, otherwise hold.
      always_comb begin
         vld_d  = vld_q;
         data_d = data_q;
         if (flush_in) begin
            vld_d = 1'b0;
         end else if (load_s[g]) begin
            vld_d = src_vld_s;
            // Only valid words are copied, so q_output stays 0 after reset
            // until the first real word arrives.
            if (src_vld_s) begin
               data_d = src_data_s;
            end else begin
               data_d = data_q;
            end
         end else begin
            vld_d = vld_q;
         end
      end

      // Stage register with asynchronous clear of both valid and data.
      always_ff @(posedge clk or negedge rst_n_in) begin
         if (!rst_n_in) begin
            vld_q  <= 1'b0;
            data_q <= '0;
         end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
         end
      end

      assign vld_s[g]  = vld_q;
      assign data_s[g] = data_q;
   end

   assign ready_out  = load_s[0] && !flush_in;
   assign in_xfer_s  = valid_in && ready_out;
   assign out_xfer_s = vld_s[DEPTH-1] && ready_in;

   // Occupancy next value: flush empties, otherwise it tracks accepted minus emitted words.
   always_comb begin
      if (flush_in) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + CNT_W'(in_xfer_s) - CNT_W'(out_xfer_s);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign q_output      = data_s[DEPTH-1];
   assign valid_out     = vld_s[DEPTH-1];
   assign occupancy_out = occ_q;

`ifdef DFF_PIPE_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   // Stall counter next value: cleared by flush, bumped when the output waits on downstream.
   always_comb begin
      if (flush_in) begin
         stall_cnt_d = 16'd0;
      end else if (vld_s[DEPTH-1] && !ready_in) begin
         stall_cnt_d = sat_inc16(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Testbench for dff_pipe.
// Instance A (DEPTH=4) is driven by directed and random stimulus. A monitor
// keeps a reference model of the pipeline: a FIFO of accepted words plus a
// word count. The model says the pipe accepts whenever it is not full or the
// output is being taken, unless a flush is in progress.
// Instance B (DEPTH=1) exercises the single-stage ready rule, asynchronous
// reset and the optional stall counter.
module tb_dff_pipe;
   localparam int DA = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A
   logic        rst_n;
   logic [63:0] d_in;
   logic        valid_in;
   logic        ready_out;
   logic [63:0] q_output;
   logic        valid_out;
   logic        ready_in;
   logic        flush_in;
   logic [2:0]  occupancy_out;
   // Instance B
   logic        b_rst_n;
   logic [63:0] b_d;
   logic        b_valid;
   logic        b_ready_out;
   logic [63:0] b_q;
   logic        b_valid_out;
   logic        b_ready_in;
   logic        b_flush;
   logic [0:0]  b_occ;
`ifdef DFF_PIPE_STALL_CNT_EN
   logic [15:0] a_stall;
   logic [15:0] b_stall;
`endif

   dff_pipe #(.BIT_WIDTH(64), .DEPTH(DA)) u_a (
      .clk(clk), .rst_n_in(rst_n), .d_in(d_in), .valid_in(valid_in),
      .ready_out(ready_out), .q_output(q_output), .valid_out(valid_out),
      .ready_in(ready_in), .flush_in(flush_in), .occupancy_out(occupancy_out)
`ifdef DFF_PIPE_STALL_CNT_EN
      , .stall_cnt_out(a_stall)
`endif
   );

   dff_pipe #(.BIT_WIDTH(64), .DEPTH(1)) u_b (
      .clk(clk), .rst_n_in(b_rst_n), .d_in(b_d), .valid_in(b_valid),
      .ready_out(b_ready_out), .q_output(b_q), .valid_out(b_valid_out),
      .ready_in(b_ready_in), .flush_in(b_flush), .occupancy_out(b_occ)
`ifdef DFF_PIPE_STALL_CNT_EN
      , .stall_cnt_out(b_stall)
`endif
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state, owned by the monitor.
   logic [63:0] exp_q[$];
   int          acc_q[$];
   int          model_cnt = 0;
   int          cyc = 0;

   // Monitor: samples at the falling edge, compares, then updates the model
   // with the transfers that the next rising edge will perform.
   always @(negedge clk) begin
      logic        in_x;
      logic        out_x;
      logic [63:0] e;
      int          a;
      if (!rst_n) begin
         chk("rst_q", q_output, 64'd0);
         chk("rst_valid", {63'd0, valid_out}, 64'd0);
         chk("rst_occ", {61'd0, occupancy_out}, 64'd0);
         chk("rst_ready", {63'd0, ready_out}, 64'd1);
         exp_q.delete();
         acc_q.delete();
         model_cnt = 0;
      end else begin
         cyc++;
         chk("ready", {63'd0, ready_out},
             {63'd0, (!flush_in && (model_cnt < DA || ready_in))});
         chk("occupancy", {61'd0, occupancy_out}, 64'(model_cnt));
         if (model_cnt == 0) begin
            chk("phantom_valid", {63'd0, valid_out}, 64'd0);
         end
         in_x  = valid_in && ready_out;
         out_x = valid_out && ready_in;
         if (out_x) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", q_output, 64'hDEAD_0000_0000_DEAD);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("order", q_output, e);
               chk("latency_min", 64'(cyc - a >= DA), 64'd1);
            end
         end
         if (flush_in) begin
            exp_q.delete();
            acc_q.delete();
            model_cnt = 0;
         end else begin
            if (in_x) begin
               exp_q.push_back(d_in);
               acc_q.push_back(cyc);
            end
            model_cnt = model_cnt + int'(in_x) - int'(out_x);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w);
      int   tries;
      logic acc;
      d_in = w;
      valid_in = 1'b1;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
         tries++;
      end
      valid_in = 1'b0;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n;
      ready_in = 1'b1;
      valid_in = 1'b0;
      n = 0;
      while ((occupancy_out != 3'd0 || valid_out) && n < 40) begin
         step();
         n++;
      end
      chk("drain_occ", {61'd0, occupancy_out}, 64'd0);
      chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; d_in = 64'd0; valid_in = 1'b0; ready_in = 1'b1; flush_in = 1'b0;
      b_rst_n = 1'b0; b_d = 64'd0; b_valid = 1'b0; b_ready_in = 1'b1; b_flush = 1'b0;
      step();
      step();
      chk("rst_hold_q", q_output, 64'd0);
      chk("rst_hold_occ", {61'd0, occupancy_out}, 64'd0);
      rst_n = 1'b1;
      b_rst_n = 1'b1;

      // Reset and latency: three back-to-back words, first out 3 edges after acceptance.
      send(64'd87);
      send(64'd2);
      send(64'd68);
      step();
      chk("lat_q0", q_output, 64'd87);
      chk("lat_v0", {63'd0, valid_out}, 64'd1);
      step();
      chk("lat_q1", q_output, 64'd2);
      step();
      chk("lat_q2", q_output, 64'd68);
      step();
      chk("lat_idle", {63'd0, valid_out}, 64'd0);

      // Back-pressure: four words fill the pipe, the fifth waits.
      ready_in = 1'b0;
      for (int w = 1; w <= 4; w++) send(64'(w));
      d_in = 64'd5;
      valid_in = 1'b1;
      #1;
      chk("bp_ready", {63'd0, ready_out}, 64'd0);
      chk("bp_occ", {61'd0, occupancy_out}, 64'd4);
      chk("bp_q", q_output, 64'd1);
      step();
      step();
      chk("bp_q_held", q_output, 64'd1);
      ready_in = 1'b1;
      send(64'd5);
      send(64'd6);
      drain();

      // Bubble collapse: 10, two idle cycles, 20, then let 20 catch up.
      ready_in = 1'b0;
      send(64'd10);
      step();
      step();
      send(64'd20);
      step();
      step();
      step();
      #1;
      chk("bub_occ", {61'd0, occupancy_out}, 64'd2);
      chk("bub_ready", {63'd0, ready_out}, 64'd1);
      ready_in = 1'b1;
      chk("bub_q0", q_output, 64'd10);
      step();
      chk("bub_q1", q_output, 64'd20);
      chk("bub_v1", {63'd0, valid_out}, 64'd1);
      step();
      chk("bub_empty", {63'd0, valid_out}, 64'd0);

      // Full pass-through: occupancy stays at 4 while words stream in and out.
      ready_in = 1'b0;
      for (int w = 30; w <= 33; w++) send(64'(w));
      ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d_in = 64'(100 + k);
         valid_in = 1'b1;
         #1;
         chk("full_ready", {63'd0, ready_out}, 64'd1);
         chk("full_occ", {61'd0, occupancy_out}, 64'd4);
         step();
      end
      valid_in = 1'b0;
      chk("full_occ_end", {61'd0, occupancy_out}, 64'd4);
      drain();

      // Flush with a word offered: nothing survives and 55 never appears.
      ready_in = 1'b0;
      send(64'd40);
      send(64'd41);
      send(64'd42);
      d_in = 64'd55;
      valid_in = 1'b1;
      flush_in = 1'b1;
      #1;
      chk("flush_ready", {63'd0, ready_out}, 64'd0);
      step();
      flush_in = 1'b0;
      valid_in = 1'b0;
      chk("flush_occ", {61'd0, occupancy_out}, 64'd0);
      chk("flush_valid", {63'd0, valid_out}, 64'd0);
      ready_in = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("flush_quiet", {63'd0, valid_out}, 64'd0);
      end

      // Random traffic with occasional flushes.
      for (int k = 0; k < 400; k++) begin
         valid_in = ($urandom_range(0, 9) < 7);
         ready_in = ($urandom_range(0, 9) < 6);
         flush_in = ($urandom_range(0, 39) == 0);
         d_in = {$urandom, $urandom};
         step();
      end
      flush_in = 1'b0;
      drain();

      // DEPTH=1: stall, single-stage ready rule, asynchronous reset mid-cycle.
      b_ready_in = 1'b0;
      b_valid = 1'b1;
      b_d = 64'd77;
      #1;
      chk("b_ready_empty", {63'd0, b_ready_out}, 64'd1);
      step();
      b_valid = 1'b0;
      chk("b_q", b_q, 64'd77);
      chk("b_valid", {63'd0, b_valid_out}, 64'd1);
      chk("b_occ", {63'd0, b_occ}, 64'd1);
      chk("b_ready_full", {63'd0, b_ready_out}, 64'd0);
      for (int k = 0; k < 5; k++) step();
      chk("b_q_held", b_q, 64'd77);
`ifdef DFF_PIPE_STALL_CNT_EN
      chk("b_stall5", {48'd0, b_stall}, 64'd5);
`endif
      b_ready_in = 1'b1;
      #1;
      chk("b_ready_pass", {63'd0, b_ready_out}, 64'd1);
      b_ready_in = 1'b0;
      #1;
      b_rst_n = 1'b0;
      #1;
      chk("b_arst_valid", {63'd0, b_valid_out}, 64'd0);
      chk("b_arst_q", b_q, 64'd0);
      chk("b_arst_occ", {63'd0, b_occ}, 64'd0);
`ifdef DFF_PIPE_STALL_CNT_EN
      chk("b_arst_stall", {48'd0, b_stall}, 64'd0);
`endif
      step();
      b_rst_n = 1'b1;
      step();
      chk("b_after_rst", {63'd0, b_valid_out}, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised elastic register pipeline; successor to the single-stage 64-bit dff.
- Carries a BIT_WIDTH data word through DEPTH register stages with valid/ready handshaking, bubble collapsing, synchronous flush and an occupancy count.
- Intended as the inter-iteration register chain in the CORDIC datapath, where downstream back-pressure must stall the chain without dropping words.

Parameters:
- BIT_WIDTH, 64, data word width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- CNT_W, $clog2(DEPTH+1), width of occupancy_out (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous reset, active-low
- d_in  input  BIT_WIDTH  upstream data word
- valid_in  input  1  d_in holds a valid word
- ready_out  output  1  pipeline accepts d_in this cycle
- q_output  output  BIT_WIDTH  data word of the last stage
- valid_out  output  1  q_output holds a valid word
- ready_in  input  1  downstream accepts q_output this cycle
- flush_in  input  1  synchronous discard of all contents
- occupancy_out  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Stages: data[0..DEPTH-1] and vld[0..DEPTH-1]. Stage 0 is the input side; stage DEPTH-1 drives q_output/valid_out.
- Reset (rst_n_in low, asynchronous): all vld=0, all data=0.
  - q_output=0, valid_out=0, occupancy_out=0.
  - ready_out=1 once flush_in is low.
  - Release is synchronous to clk in the system; the block needs no internal synchroniser.
- Advance rules (combinational, evaluated from the last stage back):
  - adv[DEPTH-1] = ready_in.
  - adv[i] = !vld[i+1] || adv[i+1] for i < DEPTH-1.
  - Stage i loads from stage i-1 (or from d_in for i=0) when adv[i]. It then takes vld[i-1] (valid_in for i=0).
  - Stage i holds when !adv[i] && vld[i].
  - Stage i clears vld when adv[i] and its source is invalid.
- ready_out = adv[0] && !flush_in.
- Input transfer on valid_in && ready_out. Output transfer on valid_out && ready_in.
- Bubble collapsing: an empty stage always accepts, so words compact toward the output while the output stalls.
- Latency: a word accepted at edge N appears on q_output with valid_out=1 after edge N+DEPTH-1, provided there are no stalls. Throughput is 1 word/cycle at ready_in=1.
- Full: all vld=1 and ready_in=0 gives ready_out=0, and everything holds.
- Full with ready_in=1: ready_out=1; simultaneous input and output, occupancy unchanged.
- Data in invalid stages is don't-care internally, but q_output must be 0 after reset until the first word arrives.
- flush_in=1 at an edge:
  - All vld cleared; occupancy_out=0 next cycle.
  - The word offered on d_in that cycle is not accepted, since ready_out is 0.
  - An output transfer in the same cycle still counts as consumed by downstream.
  - Data registers are not required to clear.
- Flush has priority over every advance. Reset has priority over flush.
- occupancy_out: registered population count of vld. Updated every edge as old + in_xfer - out_xfer, or 0 on flush.
- DEPTH=1: a single stage. ready_out = !vld[0] || ready_in.
- Reset asserted mid-stream: contents are lost immediately, with no partial-output glitch beyond the asynchronous clear.

Optional Feature:
- Macro: DFF_PIPE_STALL_CNT_EN.
- Defined: adds output stall_cnt_out [15:0].
  - Increments each edge where valid_out && !ready_in; saturates at 16'hFFFF.
  - Cleared by reset and by flush_in.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset/latency (DEPTH=4, ready_in=1): hold rst_n_in low for 2 cycles, expect q_output=0, valid_out=0, occupancy_out=0. Release, then send 87, 2, 68 on consecutive cycles. Expect 87 on q_output 3 edges after acceptance, then 2, then 68 on consecutive cycles, then valid_out=0.
- Back-pressure: with ready_in=0, stream 1..6 at valid_in=1. Expect words 1..4 accepted, ready_out=0 from the cycle occupancy_out=4, and q_output=1 held. Raise ready_in, expect 1..6 out in order with no loss or duplication.
- Bubble collapse: accept 10, idle 2 cycles, accept 20 with ready_in=0. Expect occupancy_out=2 and ready_out=1. Release ready_in, expect 10 then 20 on consecutive cycles.
- Full pass-through: fill to 4, then hold ready_in=1 and valid_in=1 with 100..103. Expect ready_out=1, occupancy_out constant at 4, and one word out per cycle.
- Flush: occupancy 3, assert flush_in with valid_in=1, d_in=55. Expect ready_out=0 that cycle, occupancy_out=0 and valid_out=0 next cycle, and 55 never emitted.
- Async reset mid-stream plus stall counter (DFF_PIPE_STALL_CNT_EN, DEPTH=1): stall 5 cycles, expect stall_cnt_out=5. Pull rst_n_in low between edges, expect valid_out=0 and stall_cnt_out=0 immediately, without waiting for an edge.
